// File: rtl/ct_ifu_ind_btb_pkg.sv
// Shared constants, update-entry payload and index hash for the indirect-BTB access path.
package ct_ifu_ind_btb_pkg;

  localparam int unsigned IDX_W      = 8;
  localparam int unsigned DATA_W     = 23;
  localparam int unsigned HIST_W     = 8;
  localparam int unsigned PC_W       = 12;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] target;
  } upd_entry_t;

  // Callers pass pc[10:3]; history width matches the index width.
  function automatic logic [IDX_W-1:0] idx_hash(input logic [IDX_W-1:0]  pc_bits,
                                                input logic [HIST_W-1:0] hist);
    return pc_bits ^ hist;
  endfunction

endpackage

// File: rtl/ct_ifu_ind_btb_upd_fifo.sv
// Circular FIFO of pending BTB target updates; exposes all slots for the bypass compare.
module ct_ifu_ind_btb_upd_fifo
  import ct_ifu_ind_btb_pkg::*;
#(
  parameter  int unsigned DEPTH = FIFO_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         push,
  input  upd_entry_t                   push_entry,
  input  logic                         pop,
  output logic                         full,
  output logic                         empty,
  output upd_entry_t                   head,
  output logic [CNT_W-1:0]             count,
  output logic [PTR_W-1:0]             rd_ptr,
  output upd_entry_t [DEPTH-1:0]       entries
);

  upd_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign entries = mem_q;

endmodule

// File: rtl/ct_ifu_ind_btb_ctrl.sv
// Indirect-BTB SRAM access controller: index hash, update buffering, port arbitration.
// Optional CT_IFU_IND_BTB_BYPASS_EN forwards queued targets to matching lookups.
module ct_ifu_ind_btb_ctrl
  import ct_ifu_ind_btb_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              rd_req_vld,
  input  logic [PC_W-1:0]   rd_req_pc,
  input  logic [HIST_W-1:0] rd_req_hist,
  output logic              rd_req_grant,
  output logic              rd_data_vld,
  output logic [DATA_W-1:0] rd_data,
  input  logic              upd_vld,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [HIST_W-1:0] upd_hist,
  input  logic [DATA_W-1:0] upd_target,
  output logic              upd_ready,
  output logic              ind_btb_clk_en,
  output logic              ind_btb_cen_b,
  output logic              ind_btb_wen_b,
  output logic [IDX_W-1:0]  ind_btb_index,
  output logic [DATA_W-1:0] ind_btb_data_in,
  input  logic [DATA_W-1:0] ind_btb_dout
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic                        fifo_full, fifo_empty, push, pop;
  upd_entry_t                  fifo_head, push_entry;
  upd_entry_t [FIFO_DEPTH-1:0] fifo_entries;
  logic [CNT_W-1:0]            fifo_count;
  logic [PTR_W-1:0]            fifo_rd_ptr;
  logic [IDX_W-1:0]            rd_idx;
  logic                        grant, cen_b, wen_b;
  logic [IDX_W-1:0]            index;
  logic [DATA_W-1:0]           data_in;
  logic                        rd_vld_q, rd_vld_d;
  logic                        unused_pc;

  assign rd_idx            = idx_hash(rd_req_pc[10:3], rd_req_hist);
  assign push_entry.idx    = idx_hash(upd_pc[10:3], upd_hist);
  assign push_entry.target = upd_target;
  assign unused_pc         = ^{rd_req_pc[11], rd_req_pc[2:0], upd_pc[11], upd_pc[2:0]};

  // Ready looks only at the registered count, so a full FIFO never takes a push.
  assign upd_ready = ~fifo_full;
  assign push      = upd_vld & ~fifo_full;

  ct_ifu_ind_btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_upd_fifo (
    .clk        (forever_cpuclk),
    .rst_b      (cpurst_b),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head),
    .count      (fifo_count),
    .rd_ptr     (fifo_rd_ptr),
    .entries    (fifo_entries)
  );

  // Full FIFO drains first, then lookups, then background drain; idle under reset.
  always_comb begin
    grant   = 1'b0;
    pop     = 1'b0;
    cen_b   = 1'b1;
    wen_b   = 1'b1;
    index   = '0;
    data_in = '0;
    if (!cpurst_b) begin
      grant = 1'b0;
    end else if (fifo_full || (!rd_req_vld && !fifo_empty)) begin
      pop     = 1'b1;
      cen_b   = 1'b0;
      wen_b   = 1'b0;
      index   = fifo_head.idx;
      data_in = fifo_head.target;
    end else if (rd_req_vld) begin
      grant = 1'b1;
      cen_b = 1'b0;
      index = rd_idx;
    end
  end

  assign rd_req_grant    = grant;
  assign ind_btb_cen_b   = cen_b;
  assign ind_btb_wen_b   = wen_b;
  assign ind_btb_clk_en  = ~cen_b;
  assign ind_btb_index   = index;
  assign ind_btb_data_in = data_in;
  assign rd_vld_d        = grant;
  assign rd_data_vld     = rd_vld_q;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) rd_vld_q <= 1'b0;
    else           rd_vld_q <= rd_vld_d;
  end

`ifdef CT_IFU_IND_BTB_BYPASS_EN
  logic              byp_hit_q, byp_hit_d;
  logic [DATA_W-1:0] byp_tgt_q, byp_tgt_d;
  logic [PTR_W-1:0]  byp_slot;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    byp_hit_d = 1'b0;
    byp_tgt_d = '0;
    byp_slot  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      byp_slot = fifo_rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < fifo_count) && (fifo_entries[byp_slot].idx == rd_idx)) begin
        byp_hit_d = grant;
        byp_tgt_d = fifo_entries[byp_slot].target;
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      byp_hit_q <= 1'b0;
      byp_tgt_q <= '0;
    end else begin
      byp_hit_q <= byp_hit_d;
      byp_tgt_q <= byp_tgt_d;
    end
  end

  assign rd_data = byp_hit_q ? byp_tgt_q : ind_btb_dout;
`else
  logic unused_byp;
  assign unused_byp = ^{fifo_entries, fifo_rd_ptr, fifo_count};
  assign rd_data    = ind_btb_dout;
`endif

endmodule

// File: tb/tb_ct_ifu_ind_btb_ctrl.sv
// Directed bench for ct_ifu_ind_btb_ctrl with a behavioural 256x23 single-port SRAM.
module tb_ct_ifu_ind_btb_ctrl;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        rd_req_vld, upd_vld, rd_req_grant, rd_data_vld, upd_ready;
  logic [11:0] rd_req_pc, upd_pc;
  logic [7:0]  rd_req_hist, upd_hist, ind_btb_index;
  logic [22:0] rd_data, upd_target, ind_btb_data_in, ind_btb_dout;
  logic        ind_btb_clk_en, ind_btb_cen_b, ind_btb_wen_b;
  logic [22:0] sram [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ct_ifu_ind_btb_ctrl dut (
    .forever_cpuclk (clk),            .cpurst_b        (rst_b),
    .rd_req_vld     (rd_req_vld),     .rd_req_pc       (rd_req_pc),
    .rd_req_hist    (rd_req_hist),    .rd_req_grant    (rd_req_grant),
    .rd_data_vld    (rd_data_vld),    .rd_data         (rd_data),
    .upd_vld        (upd_vld),        .upd_pc          (upd_pc),
    .upd_hist       (upd_hist),       .upd_target      (upd_target),
    .upd_ready      (upd_ready),      .ind_btb_clk_en  (ind_btb_clk_en),
    .ind_btb_cen_b  (ind_btb_cen_b),  .ind_btb_wen_b   (ind_btb_wen_b),
    .ind_btb_index  (ind_btb_index),  .ind_btb_data_in (ind_btb_data_in),
    .ind_btb_dout   (ind_btb_dout)
  );

  always @(posedge clk) begin
    if (!ind_btb_cen_b) begin
      if (!ind_btb_wen_b) sram[ind_btb_index] <= ind_btb_data_in;
      else                ind_btb_dout        <= sram[ind_btb_index];
    end
  end

  function automatic logic [11:0] pc_for(input logic [7:0] idx, input logic [7:0] hist);
    return {1'b0, idx ^ hist, 3'b000};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_req_vld = 1'b0; rd_req_pc = '0; rd_req_hist = '0;
    upd_vld = 1'b0; upd_pc = '0; upd_hist = '0; upd_target = '0;
  endtask

  task automatic test_reset();
    clr(); rd_req_vld = 1'b1; upd_vld = 1'b1; upd_pc = 12'h128; upd_target = 23'h55;
    cyc(); cyc(); #2;
    checks++; if (ind_btb_cen_b !== 1'b1) begin errors++; $display("FAIL rst_cen_b got=%0b exp=1", ind_btb_cen_b); end
    checks++; if (ind_btb_wen_b !== 1'b1) begin errors++; $display("FAIL rst_wen_b got=%0b exp=1", ind_btb_wen_b); end
    checks++; if (ind_btb_clk_en !== 1'b0) begin errors++; $display("FAIL rst_clk_en got=%0b exp=0", ind_btb_clk_en); end
    checks++; if (ind_btb_index !== 8'h00 || ind_btb_data_in !== 23'h0) begin errors++; $display("FAIL rst_idx_data got=%h/%h exp=0/0", ind_btb_index, ind_btb_data_in); end
    checks++; if (rd_req_grant !== 1'b0) begin errors++; $display("FAIL rst_grant got=%0b exp=0", rd_req_grant); end
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rst_rd_vld got=%0b exp=0", rd_data_vld); end
    checks++; if (upd_ready !== 1'b1) begin errors++; $display("FAIL rst_upd_ready got=%0b exp=1", upd_ready); end
    cyc(); rst_b = 1'b1; clr(); #2;
    checks++; if (ind_btb_cen_b !== 1'b1) begin errors++; $display("FAIL rst_release_idle got=%0b exp=1", ind_btb_cen_b); end
  endtask

  task automatic test_write_read();
    cyc(); clr(); upd_vld = 1'b1; upd_pc = 12'h128; upd_hist = 8'h05; upd_target = 23'h1ABCDE; #2;
    checks++; if (ind_btb_cen_b !== 1'b1) begin errors++; $display("FAIL wr_empty_idle got=%0b exp=1", ind_btb_cen_b); end
    cyc(); clr(); #2;
    checks++; if (ind_btb_cen_b !== 1'b0 || ind_btb_wen_b !== 1'b0 || ind_btb_clk_en !== 1'b1) begin errors++; $display("FAIL wr_ctl got=cen%0b wen%0b en%0b exp=0 0 1", ind_btb_cen_b, ind_btb_wen_b, ind_btb_clk_en); end
    checks++; if (ind_btb_index !== 8'h20) begin errors++; $display("FAIL wr_index got=%h exp=20", ind_btb_index); end
    checks++; if (ind_btb_data_in !== 23'h1ABCDE) begin errors++; $display("FAIL wr_data got=%h exp=1abcde", ind_btb_data_in); end
    cyc(); clr(); rd_req_vld = 1'b1; rd_req_pc = 12'h128; rd_req_hist = 8'h05; #2;
    checks++; if (rd_req_grant !== 1'b1 || ind_btb_cen_b !== 1'b0 || ind_btb_wen_b !== 1'b1) begin errors++; $display("FAIL rd_ctl got=g%0b cen%0b wen%0b exp=1 0 1", rd_req_grant, ind_btb_cen_b, ind_btb_wen_b); end
    checks++; if (ind_btb_index !== 8'h20) begin errors++; $display("FAIL rd_index got=%h exp=20", ind_btb_index); end
    cyc(); clr(); #2;
    checks++; if (rd_data_vld !== 1'b1 || rd_data !== 23'h1ABCDE) begin errors++; $display("FAIL rd_result got=v%0b %h exp=1 1abcde", rd_data_vld, rd_data); end
    cyc(); clr(); #2;
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL rd_vld_pulse got=%0b exp=0", rd_data_vld); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      cyc(); clr(); rd_req_vld = 1'b1; upd_vld = 1'b1;
      upd_pc = pc_for(8'(8'h10 + i), 8'h00); upd_target = 23'(32'h100 + i); #2;
      checks++; if (rd_req_grant !== 1'b1) begin errors++; $display("FAIL full_fill_grant%0d got=%0b exp=1", i, rd_req_grant); end
    end
    cyc(); clr(); rd_req_vld = 1'b1; upd_vld = 1'b1; upd_pc = 12'h7F8; upd_target = 23'h7ABCD; #2;
    checks++; if (upd_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%0b exp=0", upd_ready); end
    checks++; if (rd_req_grant !== 1'b0) begin errors++; $display("FAIL full_deny got=%0b exp=0", rd_req_grant); end
    checks++; if (ind_btb_cen_b !== 1'b0 || ind_btb_wen_b !== 1'b0 || ind_btb_index !== 8'h10 || ind_btb_data_in !== 23'h100) begin errors++; $display("FAIL full_write got=cen%0b wen%0b %h %h exp=0 0 10 100", ind_btb_cen_b, ind_btb_wen_b, ind_btb_index, ind_btb_data_in); end
    checks++; if (rd_data_vld !== 1'b1) begin errors++; $display("FAIL full_prev_rd_vld got=%0b exp=1", rd_data_vld); end
    cyc(); clr(); rd_req_vld = 1'b1; #2;
    checks++; if (upd_ready !== 1'b1 || rd_req_grant !== 1'b1) begin errors++; $display("FAIL full_recover got=rdy%0b g%0b exp=1 1", upd_ready, rd_req_grant); end
    checks++; if (rd_data_vld !== 1'b0) begin errors++; $display("FAIL full_denied_vld got=%0b exp=0", rd_data_vld); end
    for (int j = 0; j < 3; j++) begin
      cyc(); clr(); #2;
      checks++; if (ind_btb_wen_b !== 1'b0 || ind_btb_index !== 8'(8'h11 + j) || ind_btb_data_in !== 23'(32'h101 + j)) begin errors++; $display("FAIL full_drain%0d got=wen%0b %h %h exp=0 %h %h", j, ind_btb_wen_b, ind_btb_index, ind_btb_data_in, 8'(8'h11 + j), 23'(32'h101 + j)); end
    end
    cyc(); clr(); #2;
    checks++; if (ind_btb_cen_b !== 1'b1) begin errors++; $display("FAIL full_no_extra got=%0b exp=1", ind_btb_cen_b); end
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 10; k++) begin
      cyc(); clr(); rd_req_vld = (k < 2); upd_vld = 1'b1;
      upd_pc = pc_for(8'(8'h40 + k), 8'h0F); upd_hist = 8'h0F; upd_target = 23'(32'h200 + k); #2;
      if (k >= 2) begin
        checks++; if (ind_btb_wen_b !== 1'b0 || ind_btb_index !== 8'(8'h40 + k - 2) || ind_btb_data_in !== 23'(32'h200 + k - 2) || upd_ready !== 1'b1) begin errors++; $display("FAIL wrap_pushpop%0d got=wen%0b %h %h rdy%0b exp=0 %h %h 1", k, ind_btb_wen_b, ind_btb_index, ind_btb_data_in, upd_ready, 8'(8'h40 + k - 2), 23'(32'h200 + k - 2)); end
      end
    end
    for (int j = 0; j < 2; j++) begin
      cyc(); clr(); #2;
      checks++; if (ind_btb_wen_b !== 1'b0 || ind_btb_index !== 8'(8'h48 + j)) begin errors++; $display("FAIL wrap_drain%0d got=wen%0b %h exp=0 %h", j, ind_btb_wen_b, ind_btb_index, 8'(8'h48 + j)); end
    end
    cyc(); clr(); rd_req_vld = 1'b1; rd_req_pc = pc_for(8'h49, 8'h0F); rd_req_hist = 8'h0F; #2;
    checks++; if (rd_req_grant !== 1'b1 || ind_btb_index !== 8'h49) begin errors++; $display("FAIL wrap_rd got=g%0b %h exp=1 49", rd_req_grant, ind_btb_index); end
    cyc(); clr(); #2;
    checks++; if (rd_data_vld !== 1'b1 || rd_data !== 23'h209) begin errors++; $display("FAIL wrap_rd_data got=v%0b %h exp=1 209", rd_data_vld, rd_data); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      cyc(); clr(); rd_req_vld = 1'b1; upd_vld = 1'b1;
      upd_pc = pc_for(8'(8'h60 + i), 8'h00); upd_target = 23'(32'h300 + i);
    end
    cyc(); clr(); rst_b = 1'b0; #2;
    checks++; if (ind_btb_cen_b !== 1'b1 || ind_btb_clk_en !== 1'b0) begin errors++; $display("FAIL mid_rst_idle got=cen%0b en%0b exp=1 0", ind_btb_cen_b, ind_btb_clk_en); end
    cyc(); rst_b = 1'b1; clr(); #2;
    checks++; if (rd_data_vld !== 1'b0 || upd_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_state got=v%0b rdy%0b exp=0 1", rd_data_vld, upd_ready); end
    for (int j = 0; j < 3; j++) begin
      checks++; if (ind_btb_cen_b !== 1'b1) begin errors++; $display("FAIL mid_rst_nowrite%0d got=%0b exp=1", j, ind_btb_cen_b); end
      cyc(); clr(); #2;
    end
    rd_req_vld = 1'b1; rd_req_pc = pc_for(8'h60, 8'h00); #2;
    cyc(); clr(); #2;
    checks++; if (rd_data_vld !== 1'b1 || rd_data !== 23'h0) begin errors++; $display("FAIL mid_rst_sram got=v%0b %h exp=1 0", rd_data_vld, rd_data); end
  endtask

  task automatic test_bypass();
    logic [22:0] exp_byp;
`ifdef CT_IFU_IND_BTB_BYPASS_EN
    exp_byp = 23'h000777;
`else
    exp_byp = 23'h1ABCDE;
`endif
    cyc(); clr(); rd_req_vld = 1'b1; upd_vld = 1'b1; upd_pc = 12'h128; upd_hist = 8'h05; upd_target = 23'h111;
    cyc(); clr(); rd_req_vld = 1'b1; upd_vld = 1'b1; upd_pc = 12'h128; upd_hist = 8'h05; upd_target = 23'h000777;
    cyc(); clr(); rd_req_vld = 1'b1; rd_req_pc = 12'h128; rd_req_hist = 8'h05; #2;
    checks++; if (rd_req_grant !== 1'b1 || ind_btb_index !== 8'h20) begin errors++; $display("FAIL byp_grant got=g%0b %h exp=1 20", rd_req_grant, ind_btb_index); end
    cyc(); clr(); #2;
    checks++; if (rd_data_vld !== 1'b1 || rd_data !== exp_byp) begin errors++; $display("FAIL byp_data got=v%0b %h exp=1 %h", rd_data_vld, rd_data, exp_byp); end
    cyc(); clr();
    cyc(); clr(); rd_req_vld = 1'b1; rd_req_pc = 12'h128; rd_req_hist = 8'h05;
    cyc(); clr(); #2;
    checks++; if (rd_data_vld !== 1'b1 || rd_data !== 23'h000777) begin errors++; $display("FAIL byp_drained got=v%0b %h exp=1 000777", rd_data_vld, rd_data); end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) sram[a] = '0;
    ind_btb_dout = '0;
    test_reset();
    test_write_read();
    test_full();
    test_wrap();
    test_reset_mid();
    test_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
